// File: rtl/mvu_bank_pkg.sv
// Shared widths, muxcode encodings and sequencer state type for the bank read path.
package mvu_bank_pkg;
  localparam int W = 128;
  localparam int A = 9;

  localparam logic [1:0] MUX_I   = 2'b00;
  localparam logic [1:0] MUX_D   = 2'b01;
  localparam logic [1:0] MUX_C   = 2'b10;
  localparam logic [1:0] MUX_BAD = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } rd_state_e;
endpackage

// File: rtl/bank_rd_fifo.sv
// Two-entry output FIFO holding {last, word}; head is driven straight from storage
// so the output stays stable while the consumer stalls.
module bank_rd_fifo #(
  parameter int DW = 129
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          push_i,
  input  logic [DW-1:0] din_i,
  input  logic          pop_i,
  output logic [DW-1:0] dout_o,
  output logic [1:0]    occ_o,
  output logic          full_o,
  output logic          empty_o
);
  logic [DW-1:0] mem_q [2];
  logic          wr_ptr_q;
  logic          rd_ptr_q;
  logic [1:0]    occ_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) rd_ptr_q <= ~rd_ptr_q;
      occ_q <= occ_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign occ_o   = occ_q;
  assign full_o  = (occ_q == 2'd2);
  assign empty_o = (occ_q == 2'd0);
endmodule

// File: rtl/bank_stream_reader.sv
// Strided read sequencer for one data bank: issues reads under a FIFO credit rule,
// absorbs the 1-cycle bank latency and presents the words as a valid/ready stream.
module bank_stream_reader
  import mvu_bank_pkg::*;
#(
  parameter int DATA_W = W,
  parameter int ADDR_W = A
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [ADDR_W-1:0] cmd_base_i,
  input  logic [ADDR_W:0]   cmd_count_i,
  input  logic [ADDR_W-1:0] cmd_stride_i,
  input  logic [1:0]        cmd_muxcode_i,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic [1:0]        rd_muxcode_o,
  input  logic [DATA_W-1:0] rd_word_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_word_o,
  output logic              out_last_o,
  output logic              busy_o,
  output logic              err_o
);
  rd_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   remain_q, remain_d;
  logic [ADDR_W-1:0] stride_q, stride_d;
  logic [1:0]        mux_q, mux_d;
  logic              infl_q, infl_d;
  logic              infl_last_q, infl_last_d;
  logic              err_q, err_d;

  logic [DATA_W:0]   fifo_dout;
  logic [1:0]        fifo_occ;
  logic              fifo_full, fifo_empty;
  logic              pop, issue_ok;
  logic [2:0]        load;

  bank_rd_fifo #(.DW(DATA_W + 1)) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (infl_q),
    .din_i   ({infl_last_q, rd_word_i}),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .occ_o   (fifo_occ),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign out_valid_o = !fifo_empty;
  assign out_word_o  = fifo_dout[DATA_W-1:0];
  assign out_last_o  = !fifo_empty && fifo_dout[DATA_W];
  assign pop         = out_valid_o && out_ready_i;

  // A read issued now lands in the FIFO next cycle; count it against the slots left after this pop.
  assign load     = {1'b0, fifo_occ} + {2'b00, infl_q};
  assign issue_ok = (load < (3'd2 + {2'b00, pop})) && !(fifo_full && !pop);

  assign cmd_ready_o  = (state_q == IDLE);
  assign busy_o       = (state_q != IDLE);
  assign rd_en_o      = (state_q == ISSUE) && issue_ok;
  assign rd_addr_o    = addr_q;
  assign rd_muxcode_o = busy_o ? mux_q : MUX_I;
  assign err_o        = err_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remain_d    = remain_q;
    stride_d    = stride_q;
    mux_d       = mux_q;
    err_d       = 1'b0;
    infl_d      = rd_en_o;
    infl_last_d = rd_en_o && (remain_q == (ADDR_W+1)'(1));
    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          err_d = (cmd_muxcode_i == MUX_BAD);
          if ((cmd_count_i != '0) && (cmd_muxcode_i != MUX_BAD)) begin
            state_d  = ISSUE;
            addr_d   = cmd_base_i;
            remain_d = cmd_count_i;
            stride_d = cmd_stride_i;
            mux_d    = cmd_muxcode_i;
          end
        end
      end
      ISSUE: begin
        if (rd_en_o) begin
          addr_d   = addr_q + stride_q;
          remain_d = remain_q - (ADDR_W+1)'(1);
          if (remain_q == (ADDR_W+1)'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && out_last_o) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remain_q    <= '0;
      stride_q    <= '0;
      mux_q       <= MUX_I;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remain_q    <= remain_d;
      stride_q    <= stride_d;
      mux_q       <= mux_d;
      infl_q      <= infl_d;
      infl_last_q <= infl_last_d;
      err_q       <= err_d;
    end
  end
endmodule

// File: tb/tb_bank_stream_reader.sv
// Directed bench for bank_stream_reader with a 1-cycle-latency bank model and an event logger.
module tb_bank_stream_reader;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [8:0]   cmd_base;
  logic [9:0]   cmd_count;
  logic [8:0]   cmd_stride;
  logic [1:0]   cmd_muxcode;
  logic         rd_en;
  logic [8:0]   rd_addr;
  logic [1:0]   rd_muxcode;
  logic [127:0] rd_word;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_word;
  logic         out_last;
  logic         busy;
  logic         err;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  int           rd_cyc[$];
  int           rd_adr[$];
  int           rd_mux[$];
  int           bt_cyc[$];
  logic [127:0] bt_word[$];
  bit           bt_last[$];
  int           err_cnt, notready_cnt, stall_viol, max_ahead;
  bit           prev_stall;
  logic [127:0] prev_word;
  logic         prev_last;

  bank_stream_reader dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .cmd_valid_i   (cmd_valid),
    .cmd_ready_o   (cmd_ready),
    .cmd_base_i    (cmd_base),
    .cmd_count_i   (cmd_count),
    .cmd_stride_i  (cmd_stride),
    .cmd_muxcode_i (cmd_muxcode),
    .rd_en_o       (rd_en),
    .rd_addr_o     (rd_addr),
    .rd_muxcode_o  (rd_muxcode),
    .rd_word_i     (rd_word),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .out_word_o    (out_word),
    .out_last_o    (out_last),
    .busy_o        (busy),
    .err_o         (err)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] bank_data(input int a);
    logic [31:0] t;
    logic [8:0]  a9;
    a9 = 9'(a);
    t  = {23'h05A3C1, a9};
    return {t, ~t, t ^ 32'h0F0F_0F0F, a9, a9, a9, 5'h0};
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_en) rd_word <= bank_data(int'(rd_addr));
  end

  always @(negedge clk) begin
    if (rd_en) begin
      rd_cyc.push_back(cyc);
      rd_adr.push_back(int'(rd_addr));
      rd_mux.push_back(int'(rd_muxcode));
    end
    if (out_valid && out_ready) begin
      bt_cyc.push_back(cyc);
      bt_word.push_back(out_word);
      bt_last.push_back(out_last);
    end
    if (err) err_cnt++;
    if (!cmd_ready) notready_cnt++;
    if (rst_n && prev_stall && (!out_valid || out_word !== prev_word || out_last !== prev_last))
      stall_viol++;
    prev_stall = rst_n && out_valid && !out_ready;
    prev_word  = out_word;
    prev_last  = out_last;
    if (rd_cyc.size() - bt_cyc.size() > max_ahead) max_ahead = rd_cyc.size() - bt_cyc.size();
  end

  task automatic clear_log();
    rd_cyc.delete(); rd_adr.delete(); rd_mux.delete();
    bt_cyc.delete(); bt_word.delete(); bt_last.delete();
    err_cnt = 0; notready_cnt = 0; stall_viol = 0; max_ahead = 0;
  endtask

  task automatic send_cmd(input int base, input int count, input int stride, input int mux,
                          output int n);
    int k;
    @(posedge clk); #1;
    cmd_valid   = 1'b1;
    cmd_base    = 9'(base);
    cmd_count   = 10'(count);
    cmd_stride  = 9'(stride);
    cmd_muxcode = 2'(mux);
    k = 0;
    @(negedge clk);
    while (!cmd_ready && k < 100) begin @(negedge clk); k++; end
    n = cyc;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output int done_cyc);
    int k;
    k = 0;
    @(negedge clk);
    while (busy && k < budget) begin @(negedge clk); k++; end
    if (busy) begin
      vectors++; miscompares++;
      $display("FAIL timeout busy still high after %0d cycles", budget);
    end
    done_cyc = cyc;
  endtask

  task automatic test_reset();
    @(negedge clk);
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL rst_cmd_ready got %b want 1", cmd_ready); end
    vectors++; if (rd_en !== 1'b0) begin miscompares++; $display("FAIL rst_rd_en got %b want 0", rd_en); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    vectors++; if (out_last !== 1'b0) begin miscompares++; $display("FAIL rst_out_last got %b want 0", out_last); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got %b want 0", busy); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL rst_err got %b want 0", err); end
    vectors++; if (rd_addr !== 9'd0) begin miscompares++; $display("FAIL rst_rd_addr got %0d want 0", rd_addr); end
    vectors++; if (rd_muxcode !== 2'd0) begin miscompares++; $display("FAIL rst_rd_muxcode got %0d want 0", rd_muxcode); end
    vectors++; if (out_word !== 128'd0) begin miscompares++; $display("FAIL rst_out_word got %h want 0", out_word); end
  endtask

  task automatic test_basic();
    int n, rc;
    clear_log();
    out_ready = 1'b1;
    send_cmd(0, 4, 1, 1, n);
    wait_idle(50, rc);
    repeat (3) @(negedge clk);
    vectors++; if (rd_cyc.size() !== 4) begin miscompares++; $display("FAIL basic_reads got %0d want 4", rd_cyc.size()); end
    for (int k = 0; k < 4 && k < rd_cyc.size(); k++) begin
      vectors++; if (rd_cyc[k] !== n + 1 + k) begin miscompares++; $display("FAIL basic_rd_cyc[%0d] got %0d want %0d", k, rd_cyc[k], n + 1 + k); end
      vectors++; if (rd_adr[k] !== k) begin miscompares++; $display("FAIL basic_rd_addr[%0d] got %0d want %0d", k, rd_adr[k], k); end
      vectors++; if (rd_mux[k] !== 1) begin miscompares++; $display("FAIL basic_rd_mux[%0d] got %0d want 1", k, rd_mux[k]); end
    end
    vectors++; if (bt_cyc.size() !== 4) begin miscompares++; $display("FAIL basic_beats got %0d want 4", bt_cyc.size()); end
    for (int k = 0; k < 4 && k < bt_cyc.size(); k++) begin
      vectors++; if (bt_cyc[k] !== n + 3 + k) begin miscompares++; $display("FAIL basic_beat_cyc[%0d] got %0d want %0d", k, bt_cyc[k], n + 3 + k); end
      vectors++; if (bt_word[k] !== bank_data(k)) begin miscompares++; $display("FAIL basic_word[%0d] got %h want %h", k, bt_word[k], bank_data(k)); end
      vectors++; if (bt_last[k] !== (k == 3)) begin miscompares++; $display("FAIL basic_last[%0d] got %b want %b", k, bt_last[k], (k == 3)); end
    end
    vectors++; if (rc !== n + 7) begin miscompares++; $display("FAIL basic_cmd_ready_cyc got %0d want %0d", rc, n + 7); end
  endtask

  task automatic test_wrap();
    int n, rc;
    clear_log();
    send_cmd(510, 4, 1, 2, n);
    wait_idle(50, rc);
    repeat (2) @(negedge clk);
    vectors++; if (rd_adr.size() !== 4) begin miscompares++; $display("FAIL wrap_reads got %0d want 4", rd_adr.size()); end
    for (int k = 0; k < 4 && k < rd_adr.size(); k++) begin
      vectors++; if (rd_adr[k] !== (510 + k) % 512) begin miscompares++; $display("FAIL wrap_addr[%0d] got %0d want %0d", k, rd_adr[k], (510 + k) % 512); end
    end
    for (int k = 0; k < 4 && k < bt_word.size(); k++) begin
      vectors++; if (bt_word[k] !== bank_data((510 + k) % 512)) begin miscompares++; $display("FAIL wrap_word[%0d] got %h want %h", k, bt_word[k], bank_data((510 + k) % 512)); end
    end
  endtask

  task automatic test_stall();
    int n, rc, i;
    bit pat[4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    clear_log();
    out_ready = 1'b1;
    send_cmd(100, 8, 3, 0, n);
    i = 0;
    while (i < 200) begin
      @(posedge clk); #1;
      out_ready = pat[i % 4];
      i++;
      @(negedge clk);
      if (!busy) break;
    end
    if (busy) begin vectors++; miscompares++; $display("FAIL stall_timeout busy still high"); end
    out_ready = 1'b1;
    wait_idle(10, rc);
    repeat (4) @(negedge clk);
    vectors++; if (rd_cyc.size() !== 8) begin miscompares++; $display("FAIL stall_reads got %0d want 8", rd_cyc.size()); end
    vectors++; if (bt_word.size() !== 8) begin miscompares++; $display("FAIL stall_beats got %0d want 8", bt_word.size()); end
    for (int k = 0; k < 8 && k < bt_word.size(); k++) begin
      vectors++; if (bt_word[k] !== bank_data((100 + 3 * k) % 512)) begin miscompares++; $display("FAIL stall_word[%0d] got %h want %h", k, bt_word[k], bank_data((100 + 3 * k) % 512)); end
      vectors++; if (bt_last[k] !== (k == 7)) begin miscompares++; $display("FAIL stall_last[%0d] got %b want %b", k, bt_last[k], (k == 7)); end
    end
    vectors++; if (stall_viol !== 0) begin miscompares++; $display("FAIL stall_stable got %0d changes want 0", stall_viol); end
    vectors++; if (max_ahead > 2) begin miscompares++; $display("FAIL stall_ahead got %0d want <=2", max_ahead); end
  endtask

  task automatic test_zero_illegal();
    int n;
    clear_log();
    send_cmd(5, 0, 1, 0, n);
    repeat (4) @(negedge clk);
    vectors++; if (rd_cyc.size() !== 0) begin miscompares++; $display("FAIL zero_reads got %0d want 0", rd_cyc.size()); end
    vectors++; if (bt_cyc.size() !== 0) begin miscompares++; $display("FAIL zero_beats got %0d want 0", bt_cyc.size()); end
    vectors++; if (err_cnt !== 0) begin miscompares++; $display("FAIL zero_err got %0d want 0", err_cnt); end
    vectors++; if (notready_cnt !== 0) begin miscompares++; $display("FAIL zero_cmd_ready_low got %0d want 0", notready_cnt); end
    clear_log();
    send_cmd(5, 5, 1, 3, n);
    repeat (4) @(negedge clk);
    vectors++; if (rd_cyc.size() !== 0) begin miscompares++; $display("FAIL illegal_reads got %0d want 0", rd_cyc.size()); end
    vectors++; if (bt_cyc.size() !== 0) begin miscompares++; $display("FAIL illegal_beats got %0d want 0", bt_cyc.size()); end
    vectors++; if (err_cnt !== 1) begin miscompares++; $display("FAIL illegal_err got %0d want 1", err_cnt); end
    vectors++; if (notready_cnt !== 0) begin miscompares++; $display("FAIL illegal_cmd_ready_low got %0d want 0", notready_cnt); end
  endtask

  task automatic test_reset_mid();
    int n, k;
    clear_log();
    out_ready = 1'b1;
    send_cmd(20, 10, 1, 2, n);
    k = 0;
    @(negedge clk);
    while (rd_cyc.size() < 3 && k < 20) begin @(negedge clk); k++; end
    if (rd_cyc.size() < 3) begin vectors++; miscompares++; $display("FAIL rmid_timeout reads got %0d want 3", rd_cyc.size()); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL rmid_cmd_ready got %b want 1", cmd_ready); end
    vectors++; if (rd_en !== 1'b0) begin miscompares++; $display("FAIL rmid_rd_en got %b want 0", rd_en); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_out_valid got %b want 0", out_valid); end
    vectors++; if (out_last !== 1'b0) begin miscompares++; $display("FAIL rmid_out_last got %b want 0", out_last); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rmid_busy got %b want 0", busy); end
    vectors++; if (rd_addr !== 9'd0) begin miscompares++; $display("FAIL rmid_rd_addr got %0d want 0", rd_addr); end
    vectors++; if (rd_muxcode !== 2'd0) begin miscompares++; $display("FAIL rmid_rd_muxcode got %0d want 0", rd_muxcode); end
    vectors++; if (out_word !== 128'd0) begin miscompares++; $display("FAIL rmid_out_word got %h want 0", out_word); end
    clear_log();
    repeat (6) @(negedge clk);
    vectors++; if (bt_cyc.size() !== 0) begin miscompares++; $display("FAIL rmid_beats_after got %0d want 0", bt_cyc.size()); end
    vectors++; if (rd_cyc.size() !== 0) begin miscompares++; $display("FAIL rmid_reads_after got %0d want 0", rd_cyc.size()); end
  endtask

  task automatic test_after_reset();
    int n, rc;
    clear_log();
    send_cmd(7, 2, 5, 0, n);
    wait_idle(30, rc);
    repeat (3) @(negedge clk);
    vectors++; if (bt_word.size() !== 2) begin miscompares++; $display("FAIL post_beats got %0d want 2", bt_word.size()); end
    for (int k = 0; k < 2 && k < bt_word.size(); k++) begin
      vectors++; if (bt_word[k] !== bank_data(7 + 5 * k)) begin miscompares++; $display("FAIL post_word[%0d] got %h want %h", k, bt_word[k], bank_data(7 + 5 * k)); end
      vectors++; if (bt_last[k] !== (k == 1)) begin miscompares++; $display("FAIL post_last[%0d] got %b want %b", k, bt_last[k], (k == 1)); end
    end
  endtask

  task automatic test_long();
    int n, rc, bad_addr, bad_word, lasts;
    clear_log();
    out_ready = 1'b1;
    send_cmd(33, 512, 0, 1, n);
    wait_idle(700, rc);
    repeat (3) @(negedge clk);
    bad_addr = 0; bad_word = 0; lasts = 0;
    foreach (rd_adr[k]) if (rd_adr[k] != 33) bad_addr++;
    foreach (bt_word[k]) begin
      if (bt_word[k] !== bank_data(33)) bad_word++;
      if (bt_last[k]) lasts++;
    end
    vectors++; if (rd_adr.size() !== 512) begin miscompares++; $display("FAIL long_reads got %0d want 512", rd_adr.size()); end
    vectors++; if (bad_addr !== 0) begin miscompares++; $display("FAIL long_addr got %0d wrong want 0", bad_addr); end
    vectors++; if (bt_word.size() !== 512) begin miscompares++; $display("FAIL long_beats got %0d want 512", bt_word.size()); end
    vectors++; if (bad_word !== 0) begin miscompares++; $display("FAIL long_word got %0d wrong want 0", bad_word); end
    vectors++; if (lasts !== 1) begin miscompares++; $display("FAIL long_last_count got %0d want 1", lasts); end
    if (bt_cyc.size() == 512) begin
      vectors++; if (bt_cyc[511] !== n + 514) begin miscompares++; $display("FAIL long_last_cyc got %0d want %0d", bt_cyc[511], n + 514); end
      vectors++; if (bt_last[511] !== 1'b1) begin miscompares++; $display("FAIL long_last_flag got %b want 1", bt_last[511]); end
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    cmd_valid   = 1'b0;
    cmd_base    = '0;
    cmd_count   = '0;
    cmd_stride  = '0;
    cmd_muxcode = '0;
    out_ready   = 1'b1;
    rd_word     = '0;
    prev_stall  = 1'b0;
    clear_log();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    test_reset();
    test_basic();
    test_wrap();
    test_stall();
    test_zero_illegal();
    test_reset_mid();
    test_after_reset();
    test_long();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/bank_stream_reader.md
# bank_stream_reader

Read-side sequencer for a `bank64k` data bank. It accepts a strided read command (base, count, stride) and issues `rd_en`/`rd_addr` to the bank. It absorbs the bank's 1-cycle read latency and returns the words as a valid/ready stream with a last marker. It sits between the MVU controller and one bank and is the consumer counterpart of the bank's write port.

## Interface
- `w`, 128, data word width; matches bank word.
- `a`, 9, bank address width; 2^a words per bank.
- `clk` in 1: single clock; bank runs on the same clock.
- `rst_n` in 1: synchronous, active-low reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_base` in a: first word address.
- `cmd_count` in a+1: number of words, 0..2^a.
- `cmd_stride` in a: address increment, applied modulo 2^a.
- `cmd_muxcode` in 2: port select, 0=i, 1=d, 2=c; 3 is illegal.
- `rd_en` out 1: bank read strobe.
- `rd_addr` out a: bank read address.
- `rd_muxcode` out 2: held at the command's muxcode while busy, 0 otherwise.
- `rd_word` in w: bank read data, valid the cycle after `rd_en`.
- `out_valid` out 1: stream word available.
- `out_ready` in 1: consumer accepts.
- `out_word` out w: stream data.
- `out_last` out 1: qualifies the final word of a command.
- `busy` out 1: state ≠ IDLE.
- `err` out 1: one-cycle pulse when an illegal muxcode is accepted.

## Operation
- States:
  - IDLE: `cmd_ready`=1. On handshake, latch base, count, stride and muxcode.
    - count=0 or muxcode=3: stay IDLE with no reads and no beats; muxcode=3 also pulses `err`.
    - Otherwise go to ISSUE.
  - ISSUE: issue one read per cycle when credit allows. After `count` reads go to DRAIN.
  - DRAIN: wait until the last beat is handshaken, then go to IDLE.
- Address: `rd_addr` = base + k·stride mod 2^a for k = 0..count−1. Wrap-around is silent. Stride 0 re-reads base.
- Credit rule: issue when occ + inflight − pop < 2.
  - occ: entries in the 2-entry output FIFO.
  - inflight: 0 or 1 (read issued in the previous cycle).
  - pop: `out_valid & out_ready` in the current cycle.
  - This guarantees no overflow and allows 1 word/cycle under continuous `out_ready`.
- Capture: FIFO pushes `rd_word` in the cycle after each `rd_en`. `out_last` is tagged on the word from read k=count−1.
- `out_word` and `out_last` stay stable while `out_valid & !out_ready`.
- Reset mid-command: FIFO emptied, any in-flight read discarded, return to IDLE.
- Reset values: `cmd_ready`=1; `rd_en`, `out_valid`, `out_last`, `busy`, `err` = 0; `rd_addr`, `rd_muxcode` = 0; `out_word` = 0.

## Timing
- Command handshake at edge ending cycle N:
  - cycle N+1: `rd_en`=1, `rd_addr`=base.
  - cycle N+2: `rd_word` valid.
  - cycle N+3: `out_valid`=1 at the earliest.
- Steady state with `out_ready`=1: one word per cycle. A count-C command has its last beat at N+2+C.
- `out_ready` low: issue stops within one cycle. At most 2 words are buffered, and none is lost.
- `cmd_ready` rises the cycle after the last beat handshake. Back-to-back commands have a 1-cycle IDLE gap.
- `rd_en` never asserts in IDLE or DRAIN.

## Structure
- Package `mvu_bank_pkg`:
  - default `W`=128 and `A`=9;
  - muxcode constants `MUX_I`=2'b00, `MUX_D`=2'b01, `MUX_C`=2'b10;
  - state enum {IDLE, ISSUE, DRAIN}.
- Sub-module `bank_rd_fifo`: 2-entry FIFO, w+1 bits wide (data + last), with push, pop, occ[1:0], full and empty.
- Top-level logic: address accumulator, remaining counter (a+1 bits), inflight flag, credit compare and FSM.

## Test plan
- base=0, count=4, stride=1, `out_ready`=1: reads at addresses 0,1,2,3 in N+1..N+4; beats at N+3..N+6; `out_last` only on word 3; `cmd_ready` back at N+7.
- base=510, count=4, stride=1: `rd_addr` = 510, 511, 0, 1, confirming wrap-around.
- count=8 with `out_ready` toggling 1,0,0,1,…: no dropped or duplicated word, `out_word` stable while stalled, at most 2 reads ahead of the consumer, and exactly 8 beats.
- count=0, then muxcode=3 with count=5: zero `rd_en` in both cases, `err` pulses once for the second command only, and `cmd_ready` stays 1.
- Drive `rst_n`=0 for one cycle in ISSUE after 3 reads of count=10: all outputs take their reset values next cycle, and no further `out_valid`.
- Then issue count=2: clean stream of 2 beats only.
- count=512, stride=0, `out_ready`=1: 512 reads of base, last beat at N+514.
